// File: rtl/ddr3_pll_seq_if.sv
// Signal bundle between the PLL power-up sequencer and the PLL / DDR3 domain.
// The sequencer side uses the master modport; the PLL/model side uses slave.
interface ddr3_pll_seq_if;
    logic       pll_lock;
    logic       pll_reset;
    logic       pll_enclk0;
    logic       pll_enclk2;
    logic       sys_rst;
    logic       ready;
    logic       fail;
    logic [7:0] relock_count;

    modport master (
        input  pll_lock,
        output pll_reset,
        output pll_enclk0,
        output pll_enclk2,
        output sys_rst,
        output ready,
        output fail,
        output relock_count
    );

    modport slave (
        output pll_lock,
        input  pll_reset,
        input  pll_enclk0,
        input  pll_enclk2,
        input  sys_rst,
        input  ready,
        input  fail,
        input  relock_count
    );
endinterface

// File: rtl/ddr3_pll_seq.sv
// DDR3 clocking PLL power-up / recovery sequencer.
// Pulses the PLL reset, qualifies a synchronised lock, enables both PLL
// outputs together, then releases the controller reset. Any lock loss
// re-runs the sequence; repeated lock timeouts end in a terminal FAIL state.
module ddr3_pll_seq #(
    parameter int RST_CYCLES         = 16,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int ENCLK_GAP          = 8,
    parameter int LOCK_TIMEOUT       = 65535,
    parameter int MAX_RETRIES        = 3
) (
    input  logic clkin,
    input  logic reset,
    ddr3_pll_seq_if.master bus
);

    localparam logic [2:0] ST_PRST  = 3'd0;
    localparam logic [2:0] ST_WAIT  = 3'd1;
    localparam logic [2:0] ST_STAB  = 3'd2;
    localparam logic [2:0] ST_ENCLK = 3'd3;
    localparam logic [2:0] ST_RUN   = 3'd4;
    localparam logic [2:0] ST_FAIL  = 3'd5;

    // Shared counter is sized for the longest interval of any state.
    localparam int MAX_AB  = (RST_CYCLES > LOCK_STABLE_CYCLES) ? RST_CYCLES : LOCK_STABLE_CYCLES;
    localparam int MAX_CD  = (ENCLK_GAP > LOCK_TIMEOUT) ? ENCLK_GAP : LOCK_TIMEOUT;
    localparam int MAX_ALL = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW      = $clog2(MAX_ALL) + 1;
    localparam int RW      = $clog2(MAX_RETRIES + 1);

    // Terminal counts: the counter starts at 0 on state entry and the state
    // ends on the edge where it holds the value (interval - 1).
    localparam logic [CW-1:0] RST_LAST   = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] STAB_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(ENCLK_GAP - 1);
    localparam logic [CW-1:0] TO_LAST    = CW'(LOCK_TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRIES - 1);

    logic          lock_meta_q;
    logic          lock_s_q;
    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [7:0]    relock_q, relock_d;
    logic          pll_reset_q, pll_reset_d;
    logic          enclk_q, enclk_d;
    logic          sys_rst_q, sys_rst_d;
    logic          ready_q, ready_d;
    logic          fail_q, fail_d;

    // Two-flop synchroniser for the raw PLL lock.
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            lock_meta_q <= bus.pll_lock;
            lock_s_q    <= lock_meta_q;
        end
    end

    // Next-state, shared counter, retry and relock bookkeeping.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        retry_d  = retry_q;
        relock_d = relock_q;
        case (state_q)
            ST_PRST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Lock takes priority over a coincident timeout.
                if (lock_s_q) begin
                    state_d = ST_STAB;
                end else if (cnt_q == TO_LAST) begin
                    retry_d = retry_q + 1'b1;
                    state_d = (retry_q == RETRY_LAST) ? ST_FAIL : ST_PRST;
                end
            end
            ST_STAB: begin
                if (!lock_s_q) begin
                    state_d = ST_WAIT;
                end else if (cnt_q == STAB_LAST) begin
                    state_d = ST_ENCLK;
                end
            end
            ST_ENCLK: begin
                if (!lock_s_q) begin
                    state_d = ST_PRST;
                end else if (cnt_q == GAP_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // No interval to time here; hold the counter.
                cnt_d = cnt_q;
                if (!lock_s_q) begin
                    state_d = ST_PRST;
                    if (relock_q != 8'hFF) begin
                        relock_d = relock_q + 8'd1;
                    end
                end
            end
            ST_FAIL: begin
                cnt_d = cnt_q;
            end
            default: begin
                state_d = ST_PRST;
            end
        endcase
        if (state_d != state_q) begin
            cnt_d = '0;
        end
        if ((state_d == ST_RUN) && (state_q != ST_RUN)) begin
            retry_d = '0;
        end
    end

    // Outputs are decoded from the next state so they move with the transition.
    always_comb begin
        pll_reset_d = (state_d == ST_PRST) || (state_d == ST_FAIL);
        enclk_d     = (state_d == ST_ENCLK) || (state_d == ST_RUN);
        sys_rst_d   = (state_d != ST_RUN);
        ready_d     = (state_d == ST_RUN);
        fail_d      = (state_d == ST_FAIL);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            state_q     <= ST_PRST;
            cnt_q       <= '0;
            retry_q     <= '0;
            relock_q    <= 8'd0;
            pll_reset_q <= 1'b1;
            enclk_q     <= 1'b0;
            sys_rst_q   <= 1'b1;
            ready_q     <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            relock_q    <= relock_d;
            pll_reset_q <= pll_reset_d;
            enclk_q     <= enclk_d;
            sys_rst_q   <= sys_rst_d;
            ready_q     <= ready_d;
            fail_q      <= fail_d;
        end
    end

    // Both PLL output enables come from one flop so they can never diverge.
    assign bus.pll_reset    = pll_reset_q;
    assign bus.pll_enclk0   = enclk_q;
    assign bus.pll_enclk2   = enclk_q;
    assign bus.sys_rst      = sys_rst_q;
    assign bus.ready        = ready_q;
    assign bus.fail         = fail_q;
    assign bus.relock_count = relock_q;

endmodule
